prog_loader: RTL and testbench

- Writer side of the CPU's 18-bit instruction memory, which the CPU reads combinationally by PC.
- Receives a framed byte stream over a valid/ready handshake (from a UART receiver or a bench) and assembles 18-bit instruction words.
- Writes each word into instruction memory, then releases the CPU run-enable.
- Holds the CPU disabled (cpu_en low) for the whole load, and leaves it disabled if the load fails.

---
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Writer side of the CPU instruction memory: receives a framed byte stream
// (HDR, N x 3 data bytes, XOR CHK), writes 18-bit words and gates the CPU run-enable.
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_en,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned CAPACITY = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_B0, S_B1, S_B2, S_WR, S_CHK, S_DONE, S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              cpu_en_q, cpu_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              xfer;
    logic [ADDR_W:0]   words_inc;

    assign xfer      = in_valid & in_ready;
    assign words_inc = words_q + (ADDR_W+1)'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            checksum_q <= '0;
            count_q    <= '0;
            words_q    <= '0;
            word_q     <= '0;
            cpu_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            checksum_q <= checksum_d;
            count_q    <= count_d;
            words_q    <= words_d;
            word_q     <= word_d;
            cpu_en_q   <= cpu_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        checksum_d = checksum_q;
        count_d    = count_q;
        words_d    = words_q;
        word_d     = word_q;
        cpu_en_d   = cpu_en_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    cpu_en_d   = 1'b0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    checksum_d = '0;
                    words_d    = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    checksum_d = checksum_q ^ in_data;
                    count_d    = (ADDR_W+1)'(in_data);
                    if (in_data == 8'd0 || 32'(in_data) > CAPACITY) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            // Word packing is MSB first; only the low two bits of B0 carry data.
            S_B0: begin
                if (xfer) begin
                    checksum_d    = checksum_q ^ in_data;
                    word_d[17:16] = in_data[1:0];
                    state_d       = S_B1;
                end
            end
            S_B1: begin
                if (xfer) begin
                    checksum_d   = checksum_q ^ in_data;
                    word_d[15:8] = in_data;
                    state_d      = S_B2;
                end
            end
            S_B2: begin
                if (xfer) begin
                    checksum_d  = checksum_q ^ in_data;
                    word_d[7:0] = in_data;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                words_d = words_inc;
                state_d = (words_inc == count_q) ? S_CHK : S_B0;
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == checksum_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        cpu_en_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and write strobe decode straight from the state register.
    assign in_ready     = (state_q inside {S_HDR, S_B0, S_B1, S_B2, S_CHK});
    assign imem_we      = (state_q == S_WR);
    assign imem_addr    = words_q[ADDR_W-1:0];
    assign imem_wdata   = word_q;
    assign cpu_en       = cpu_en_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from a word list, expected writes go into
// a scoreboard queue, and a negedge monitor pops and compares every imem_we pulse.
module tb_prog_loader;
    localparam int ADDR_W = 4;
    localparam int CAP    = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [17:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [17:0]       imem_wdata;
    logic              cpu_en;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_q[$];

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_en(cpu_en), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, and each write strobe matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("done_err_we_cpu_excl", {30'b0, done & err, imem_we & cpu_en}, 32'd0);
            if (imem_we) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", 32'(imem_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // Presents one byte, with random idle (in_valid=0, junk data) cycles first,
    // and returns just after the rising edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int guard;
        while ($urandom_range(99) < 32'(gap_pct)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                $display("FAIL byte_accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
                $fatal(1, "loader stalled");
            end
        end
        @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one frame. bad_mask!=0 corrupts CHK; b0_hi<0 randomises B0[7:2];
    // start_after / rst_after (word index, -1 = never) inject mid-load events.
    task automatic run_frame(input logic [7:0] hdr, input logic [17:0] words[$],
                             input logic [7:0] bad_mask, input int gap,
                             input int b0_hi, input int start_after, input int rst_after);
        logic [7:0] chk, b0, b1, b2;
        bit hdr_ok;
        int n, n_wr;
        hdr_ok = (hdr != 8'd0) && (int'(hdr) <= CAP);
        n      = hdr_ok ? int'(hdr) : 0;
        n_wr   = (rst_after >= 0 && rst_after + 1 < n) ? rst_after + 1 : n;
        for (int k = 0; k < n_wr; k++) exp_q.push_back('{addr: ADDR_W'(k), data: words[k]});

        pulse_start();
        check("start_cpu_en", 32'(cpu_en), 32'd0);
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_words", 32'(words_loaded), 32'd0);
        check("start_in_ready", 32'(in_ready), 32'd1);

        chk = hdr;
        send_byte(hdr, gap);
        for (int k = 0; k < n; k++) begin
            b0 = {(b0_hi < 0) ? 6'($urandom) : 6'(b0_hi), words[k][17:16]};
            b1 = words[k][15:8];
            b2 = words[k][7:0];
            chk = chk ^ b0 ^ b1 ^ b2;
            send_byte(b0, gap);
            send_byte(b1, gap);
            send_byte(b2, gap);
            if (k == start_after) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (k == rst_after) begin
                @(negedge clk);
                in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs("midload_rst");
                check("midload_rst_queue", 32'(exp_q.size()), 32'd0);
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
        end
        if (hdr_ok) send_byte(chk ^ bad_mask, gap);
        @(negedge clk);
        in_valid = 1'b0;
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_done", 32'(done), 32'(hdr_ok && bad_mask == 8'd0));
        check("end_err", 32'(err), 32'(!(hdr_ok && bad_mask == 8'd0)));
        check("end_cpu_en", 32'(cpu_en), 32'(hdr_ok && bad_mask == 8'd0));
        check("end_words", 32'(words_loaded), 32'(n));
        check("end_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [17:0] w[$];
        int n;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, valid held high, then the same frame with a bad checksum.
        w = {18'h2ABCD};
        run_frame(8'h01, w, 8'h00, 0, 0, -1, -1);
        run_frame(8'h01, w, 8'h03, 0, 0, -1, -1);

        // Header out of range.
        w = {};
        run_frame(8'h00, w, 8'h00, 0, 0, -1, -1);
        run_frame(8'h11, w, 8'h00, 0, 0, -1, -1);

        // Full-size load with gaps, B0 upper bits all ones.
        w = {};
        for (int k = 0; k < CAP; k++) w.push_back(18'h3FFF0 | 18'(k));
        run_frame(8'h10, w, 8'h00, 30, 63, -1, -1);

        // Start ignored mid-load, then reset mid-load.
        w = {};
        for (int k = 0; k < 3; k++) w.push_back(18'($urandom));
        run_frame(8'h03, w, 8'h00, 10, -1, 0, -1);
        run_frame(8'h03, w, 8'h00, 10, -1, -1, 1);

        // Reload after DONE.
        w = {18'h00001, 18'h3FFFF};
        run_frame(8'h02, w, 8'h00, 0, -1, -1, -1);
        w = {18'h15555, 18'h2AAAA};
        run_frame(8'h02, w, 8'h00, 20, -1, -1, -1);

        // Randomised frames, including occasional bad headers and checksums.
        for (int t = 0; t < 20; t++) begin
            n = int'($urandom_range(CAP + 1));
            w = {};
            for (int k = 0; k < CAP; k++) w.push_back(18'($urandom));
            run_frame(8'(n), w, ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
                      int'($urandom_range(50)), -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
